// File: rtl/gray_step_monitor.sv
// Decodes a Gray-coded sample stream to binary and classifies each step as repeat, good
// (single-bit) or bad (multi-bit), tracking direction, a saturating error count and lock state.
module gray_step_monitor #(
    parameter int N        = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     gray_in,
    input  logic             gray_valid,
    input  logic             err_clr,
    output logic [N-1:0]     bin_out,
    output logic             bin_valid,
    output logic             dir,
    output logic             step_err,
    output logic [ERR_W-1:0] err_count,
    output logic             locked
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_CNT);

    typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} state_t;

    state_t           state, state_n;
    logic [RUN_W-1:0] run, run_n;
    logic [N-1:0]     s1_gray;
    logic             s1_valid;
    logic [N-1:0]     prev_gray, prev_n;
    logic [N-1:0]     bin_new, bin_prev, bin_n;
    logic [N-1:0]     diff;
    logic             is_repeat, is_good, is_bad;
    logic             dir_n, step_err_n, bin_valid_n;
    logic [ERR_W-1:0] err_n;

    function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign bin_new   = gray2bin(s1_gray);
    assign bin_prev  = gray2bin(prev_gray);
    assign diff      = s1_gray ^ prev_gray;
    assign is_repeat = (diff == '0);
    assign is_good   = $onehot(diff);
    assign is_bad    = !is_repeat && !is_good;
    assign locked    = (state == LOCKED);

    always_comb begin
        state_n     = state;
        run_n       = run;
        prev_n      = prev_gray;
        bin_n       = bin_out;
        dir_n       = dir;
        step_err_n  = 1'b0;
        bin_valid_n = 1'b0;
        err_n       = err_count;
        if (s1_valid) begin
            bin_valid_n = 1'b1;
            bin_n       = bin_new;
            prev_n      = s1_gray;
            if (state == UNLOCKED) begin
                // First sample after reset only seeds the comparison history.
                state_n = LOCKING;
                run_n   = '0;
            end else if (is_bad) begin
                step_err_n = 1'b1;
                run_n      = '0;
                state_n    = LOCKING;
                if (err_count != '1) begin
                    err_n = ERR_W'(err_count + 1'b1);
                end
            end else if (is_good) begin
                dir_n = (bin_new == N'(bin_prev + 1'b1));
                if (run < RUN_MAX) begin
                    run_n = RUN_W'(run + 1'b1);
                end
                if (run_n == RUN_MAX) begin
                    state_n = LOCKED;
                end
            end
        end
        // Clear takes priority over an increment landing on the same edge.
        if (err_clr) begin
            err_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_gray   <= '0;
            s1_valid  <= 1'b0;
            prev_gray <= '0;
            run       <= '0;
            state     <= UNLOCKED;
            bin_out   <= '0;
            bin_valid <= 1'b0;
            dir       <= 1'b0;
            step_err  <= 1'b0;
            err_count <= '0;
        end else begin
            s1_gray   <= gray_in;
            s1_valid  <= gray_valid;
            prev_gray <= prev_n;
            run       <= run_n;
            state     <= state_n;
            bin_out   <= bin_n;
            bin_valid <= bin_valid_n;
            dir       <= dir_n;
            step_err  <= step_err_n;
            err_count <= err_n;
        end
    end

endmodule

// File: tb/tb_gray_step_monitor.sv
// Directed testbench for gray_step_monitor; ERR_W is shrunk to 2 so saturation is reachable.
module tb_gray_step_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] gray_in = '0;
    logic       gray_valid = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] bin_out;
    logic       bin_valid;
    logic       dir;
    logic       step_err;
    logic [1:0] err_count;
    logic       locked;

    int checks = 0;
    int errors = 0;

    logic [13:0] obs;
    logic [13:0] exp;

    assign obs = {bin_valid, bin_out, dir, step_err, locked, err_count};

    gray_step_monitor #(.N(8), .LOCK_CNT(4), .ERR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .gray_in   (gray_in),
        .gray_valid(gray_valid),
        .err_clr   (err_clr),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .dir       (dir),
        .step_err  (step_err),
        .err_count (err_count),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    // Inputs change on the falling edge; outputs read right after belong to the sample
    // driven two steps earlier.
    task automatic step(input logic r, input logic v, input logic [7:0] g, input logic c);
        @(negedge clk);
        reset      = r;
        gray_valid = v;
        gray_in    = g;
        err_clr    = c;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs !== 14'h0) begin
            errors++;
            $display("[TB] FAIL reset: got %h expected %h", obs, 14'h0);
        end
    endtask

    task automatic test_count_up();
        int k;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b0, i < 10, to_gray(8'(i)), 1'b0);
            if (i >= 2) begin
                k = i - 2;
                exp = {1'b1, 8'(k), 1'(k >= 1), 1'b0, 1'(k >= 4), 2'd0};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("[TB] FAIL count_up k=%0d: got %h expected %h", k, obs, exp);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] seq [6] = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};
        int k;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, i < 6, (i < 6) ? to_gray(seq[i]) : 8'h00, 1'b0);
            if (i >= 2) begin
                k = i - 2;
                exp = {1'b1, seq[k], 1'(k >= 1), 1'b0, 1'(k >= 4), 2'd0};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("[TB] FAIL wrap k=%0d: got %h expected %h", k, obs, exp);
                end
            end
        end
    endtask

    task automatic test_count_down();
        logic [7:0] seq [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd4, 8'd3};
        int k;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, i < 8, (i < 8) ? to_gray(seq[i]) : 8'h00, 1'b0);
            if (i >= 2) begin
                k = i - 2;
                exp = {1'b1, seq[k], 1'(k >= 1 && k <= 5), 1'b0, 1'(k >= 4), 2'd0};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("[TB] FAIL count_down k=%0d: got %h expected %h", k, obs, exp);
                end
            end
        end
    endtask

    task automatic test_bad_step();
        logic [7:0] gseq [10];
        logic [7:0] bseq [10] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02,
                                 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        int k;
        for (int i = 0; i < 10; i++) gseq[i] = to_gray(bseq[i]);
        gseq[5] = 8'h0C;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b0, i < 10, (i < 10) ? gseq[i] : 8'h00, 1'b0);
            if (i >= 2) begin
                k = i - 2;
                exp = {1'b1, bseq[k], 1'(k >= 1), 1'(k == 5), 1'(k == 4 || k == 9),
                       (k >= 5) ? 2'd1 : 2'd0};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("[TB] FAIL bad_step k=%0d: got %h expected %h", k, obs, exp);
                end
            end
        end
    endtask

    task automatic test_err_saturate();
        logic [7:0] gseq [6] = '{8'h00, 8'h03, 8'h00, 8'h03, 8'h00, 8'h03};
        logic [7:0] bseq [7] = '{8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 8'h02, 8'h02};
        logic [1:0] eseq [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
        int k;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1'b0, i < 6, (i < 6) ? gseq[i] : 8'h00, i == 6);
            if (i >= 2) begin
                k = i - 2;
                exp = {1'(k < 6), bseq[k], 1'b0, 1'(k >= 1 && k <= 5), 1'b0, eseq[k]};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("[TB] FAIL err_saturate k=%0d: got %h expected %h", k, obs, exp);
                end
            end
        end
    endtask

    task automatic test_gap_and_reset();
        logic [13:0] gexp [4] = '{{1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 2'd0},
                                  {1'b0, 8'd5, 1'b0, 1'b0, 1'b0, 2'd0},
                                  {1'b0, 8'd5, 1'b0, 1'b0, 1'b0, 2'd0},
                                  {1'b1, 8'd6, 1'b1, 1'b0, 1'b0, 2'd0}};
        logic       vseq [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] gseq [6] = '{8'h07, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, vseq[i], gseq[i], 1'b0);
            if (i >= 2) begin
                checks++;
                if (obs !== gexp[i-2]) begin
                    errors++;
                    $display("[TB] FAIL gap i=%0d: got %h expected %h", i, obs, gexp[i-2]);
                end
            end
        end
        // Gray 6 -> 0 is a two-bit jump, then 1..4 relock the monitor.
        for (int j = 0; j < 7; j++) step(1'b0, 1'b1, to_gray(8'(j)), 1'b0);
        exp = {1'b1, 8'd4, 1'b1, 1'b0, 1'b1, 2'd1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL pre_reset: got %h expected %h", obs, exp);
        end
        step(1'b1, 1'b1, to_gray(8'd7), 1'b0);
        step(1'b0, 1'b1, 8'hAA, 1'b0);
        checks++;
        if (obs !== 14'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got %h expected %h", obs, 14'h0);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (obs !== 14'h0) begin
            errors++;
            $display("[TB] FAIL reset_flush: got %h expected %h", obs, 14'h0);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        exp = {1'b1, 8'hCC, 1'b0, 1'b0, 1'b0, 2'd0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL post_reset: got %h expected %h", obs, exp);
        end
    endtask

    initial begin
        $display("[TB] gray_step_monitor directed tests");
        test_reset();
        test_count_up();
        test_wrap();
        test_count_down();
        test_bad_step();
        test_err_saturate();
        test_gap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
